pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 16-bit pipeline. It drives the write-enable and NOP-insert controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four conditions:
- load-use hazards
- taken-branch flushes
- fixed-latency data-memory misses
- HLT drain
Priority is miss > branch > load-use > halt.

Parameters:
MISS_LAT, 4, cycles the whole pipeline freezes per data-memory miss (legal range 1..15)
DRAIN_CYC, 3, cycles after HLT leaves ID before the pipeline reports halted (HLT reaches WB)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
id_src1  input  4  ID-stage source register 1
id_src2  input  4  ID-stage source register 2
id_uses_src2  input  1  ID instruction reads id_src2
id_halt  input  1  ID instruction is HLT
ex_memread  input  1  EX instruction is a load
ex_regwrite  input  1  EX instruction writes a register
ex_dst  input  4  EX destination register
branch_taken  input  1  branch resolved taken in EX this cycle
mem_miss  input  1  MEM-stage access missed this cycle (sampled in RUN only)
pc_wen  output  1  PC write enable
ifid_wen  output  1  IF/ID write enable
ifid_nop  output  1  IF/ID load NOP
idex_wen  output  1  ID/EX write enable
idex_nop  output  1  ID/EX load NOP
exmem_wen  output  1  EX/MEM write enable
memwb_wen  output  1  MEM/WB write enable
memwb_nop  output  1  MEM/WB load NOP
halted  output  1  pipeline fully drained after HLT
stall_cycles  output  16  stall/freeze cycle count (see Optional Feature)

Behaviour:
- State register encodes RUN, MISS, DRAIN and HALT. A 4-bit down-counter is used by MISS and DRAIN. A 16-bit counter is present only with PERF_CNT_EN.
- Reset:
  - While rst=1 (sampled at clk), the next state is RUN, the counters are 0, and halted=0.
  - During the rst cycle itself the outputs are all wen=0, all nop=1 and halted=0.
  - rst mid-MISS or mid-DRAIN aborts immediately to RUN.
- Outputs are combinational from state and inputs. Default in RUN is all wen=1, all nop=0.
- lu_hazard = ex_memread & ex_regwrite & ex_dst!=0 & (ex_dst==id_src1 | (id_uses_src2 & ex_dst==id_src2)). Register 0 never creates a hazard.
- RUN, evaluated in priority order:
  1. mem_miss=1: all wen=0. Next state MISS with counter=MISS_LAT-1. With MISS_LAT=1, the next state is RUN instead, giving exactly 1 frozen cycle.
  2. branch_taken=1: ifid_nop=1, idex_nop=1, pc_wen=1. Any simultaneous lu_hazard or id_halt is ignored because the flushed instruction is dead.
  3. lu_hazard=1: pc_wen=0, ifid_wen=0, idex_nop=1. Exactly one bubble per hazard.
  4. id_halt=1: pc_wen=0, ifid_nop=1. HLT proceeds into ID/EX. Next state DRAIN with counter=DRAIN_CYC-1.
- MISS: all wen=0 (full freeze) and inputs are ignored. The counter decrements each cycle; at 0 the next state is RUN. Total freeze = MISS_LAT cycles, including the detecting cycle.
- DRAIN: pc_wen=0 and ifid_nop=1; older stages advance. branch_taken is ignored, since HLT is the youngest live instruction. A mem_miss freezes the pipeline for MISS_LAT cycles (all wen=0) before the counter resumes. At count 0 the next state is HALT.
- HALT: all wen=0, halted=1. The block stays in HALT until rst.
- Simultaneous mem_miss and branch_taken: the miss wins. branch_taken is held by the frozen EX stage and re-evaluated on the RUN return cycle.

Optional Feature:
PERF_CNT_EN
- Defined: stall_cycles increments by 1 on every cycle after reset with pc_wen=0 and state!=HALT. It saturates at 16'hFFFF and clears on rst.
- Undefined: the counter logic is not built and stall_cycles is driven to 16'h0000.

Test Plan:
- Load-use bubble: ex_memread=1, ex_regwrite=1, ex_dst=3, id_src1=3 for one cycle. Required: pc_wen=0, ifid_wen=0, idex_nop=1 that cycle; RUN defaults the next cycle. Repeat with ex_dst=0: no stall.
- Branch over hazard: branch_taken=1 with lu_hazard=1 in the same cycle. Required: ifid_nop=1, idex_nop=1, pc_wen=1, no stall.
- Miss freeze: MISS_LAT=4, mem_miss pulse for 1 cycle. Required: all wen=0 for exactly 4 cycles, then RUN. Same pulse with branch_taken=1: freeze first, no flush during the freeze.
- Halt drain: id_halt=1 in RUN. Required: ifid_nop=1 for 1+3 cycles, halted=1 on the 5th cycle, all wen=0 thereafter.
- Reset mid-miss: rst=1 on the 2nd MISS cycle. Required: all wen=0, nops=1 during the rst cycle, then RUN defaults; stall_cycles=0.
- PERF_CNT_EN defined: 1 load-use stall plus 1 miss of MISS_LAT=4. Required: stall_cycles=5. With the macro undefined: stall_cycles=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline; PERF_CNT_EN adds a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MISS_LAT  = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_uses_src2,
  input  logic        id_halt,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  logic [3:0]  ex_dst,
  input  logic        branch_taken,
  input  logic        mem_miss,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        ifid_nop,
  output logic        idex_wen,
  output logic        idex_nop,
  output logic        exmem_wen,
  output logic        memwb_wen,
  output logic        memwb_nop,
  output logic        halted,
  output logic [15:0] stall_cycles
);
  typedef enum logic [1:0] {RUN, MISS, DRAIN, HALT} state_t;
  localparam logic [3:0] MISS_INIT  = 4'(MISS_LAT - 1);
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, hold_q, hold_d;
  logic ret_q, ret_d, freeze, lu_hazard;
  assign lu_hazard = ex_memread & ex_regwrite & (ex_dst != 4'd0) &
                     ((ex_dst == id_src1) | (id_uses_src2 & (ex_dst == id_src2)));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    ret_d = ret_q;
    freeze = 1'b0;
    pc_wen = 1'b1;
    ifid_wen = 1'b1;
    idex_wen = 1'b1;
    exmem_wen = 1'b1;
    memwb_wen = 1'b1;
    ifid_nop = 1'b0;
    idex_nop = 1'b0;
    memwb_nop = 1'b0;
    halted = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_miss) begin
          freeze = 1'b1;
          ret_d = 1'b0;
          cnt_d = MISS_INIT;
          state_d = (MISS_LAT > 1) ? MISS : RUN;
        end else if (branch_taken) begin
          ifid_nop = 1'b1;
          idex_nop = 1'b1;
        end else if (lu_hazard) begin
          pc_wen = 1'b0;
          ifid_wen = 1'b0;
          idex_nop = 1'b1;
        end else if (id_halt) begin
          pc_wen = 1'b0;
          ifid_nop = 1'b1;
          cnt_d = DRAIN_INIT;
          state_d = DRAIN;
        end
      end
      MISS: begin
        freeze = 1'b1;
        cnt_d = (cnt_q == 4'd1) ? hold_q : cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ret_q ? DRAIN : RUN;
      end
      // A miss while draining parks the drain count in hold_q until the freeze ends.
      DRAIN: begin
        if (mem_miss) begin
          freeze = 1'b1;
          ret_d = 1'b1;
          hold_d = cnt_q;
          if (MISS_LAT > 1) begin
            cnt_d = MISS_INIT;
            state_d = MISS;
          end
        end else begin
          pc_wen = 1'b0;
          ifid_nop = 1'b1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_d = HALT;
        end
      end
      default: begin
        freeze = 1'b1;
        halted = 1'b1;
      end
    endcase
    if (freeze) {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen} = 5'b0;
    if (rst) begin
      {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen} = 5'b0;
      {ifid_nop, idex_nop, memwb_nop} = 3'b111;
      halted = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= 4'd0;
      hold_q <= 4'd0;
      ret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      ret_q <= ret_d;
    end
  end
`ifdef PERF_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= 16'd0;
    else if (!pc_wen && state_q != HALT && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random stimulus checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int MISS_LAT = 4;
  localparam int DRAIN_CYC = 3;
  logic clk = 1'b0;
  logic rst, id_uses_src2, id_halt, ex_memread, ex_regwrite, branch_taken, mem_miss;
  logic [3:0] id_src1, id_src2, ex_dst;
  logic pc_wen, ifid_wen, ifid_nop, idex_wen, idex_nop, exmem_wen, memwb_wen, memwb_nop, halted;
  logic [15:0] stall_cycles;
  int total = 0, bad = 0;
  int m_freeze = 0, m_drain = 0, m_stall = 0;
  bit m_draining = 0, m_halted = 0, m_known = 0;
  pipe_hazard_ctrl #(.MISS_LAT(MISS_LAT), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .id_halt(id_halt), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_dst(ex_dst),
    .branch_taken(branch_taken), .mem_miss(mem_miss), .pc_wen(pc_wen), .ifid_wen(ifid_wen),
    .ifid_nop(ifid_nop), .idex_wen(idex_wen), .idex_nop(idex_nop), .exmem_wen(exmem_wen),
    .memwb_wen(memwb_wen), .memwb_nop(memwb_nop), .halted(halted), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic cyc(input string tag, input bit r, input bit mm, input bit br, input bit hl,
                     input bit mr, input bit rw, input logic [3:0] dst, input logic [3:0] s1,
                     input logic [3:0] s2, input bit u2);
    bit lu, pc, iw, inop, xw, xn, mw, ww, wn, h;
    logic [8:0] got, exp;
    logic [15:0] exp_stall;
    rst = r; mem_miss = mm; branch_taken = br; id_halt = hl; ex_memread = mr;
    ex_regwrite = rw; ex_dst = dst; id_src1 = s1; id_src2 = s2; id_uses_src2 = u2;
    #1;
    lu = mr && rw && dst != 0 && (dst == s1 || (u2 && dst == s2));
    {pc, iw, xw, mw, ww} = 5'b11111;
    {inop, xn, wn, h} = 4'b0000;
    if (r) begin
      {pc, iw, xw, mw, ww} = 5'b0;
      {inop, xn, wn} = 3'b111;
    end else if (m_halted) begin
      {pc, iw, xw, mw, ww} = 5'b0;
      h = 1;
    end else if (m_freeze > 0 || mm) begin
      {pc, iw, xw, mw, ww} = 5'b0;
    end else if (m_draining) begin
      pc = 0; inop = 1;
    end else if (br) begin
      inop = 1; xn = 1;
    end else if (lu) begin
      pc = 0; iw = 0; xn = 1;
    end else if (hl) begin
      pc = 0; inop = 1;
    end
    exp = {pc, iw, inop, xw, xn, mw, ww, wn, h};
    got = {pc_wen, ifid_wen, ifid_nop, idex_wen, idex_nop, exmem_wen, memwb_wen, memwb_nop, halted};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s ctl got=%b exp=%b", tag, got, exp);
    end
`ifdef PERF_CNT_EN
    exp_stall = 16'(m_stall);
`else
    exp_stall = 16'h0000;
`endif
    if (m_known) begin
      total++;
      assert (stall_cycles === exp_stall) else begin
        bad++;
        $error("FAIL %s stall got=%0d exp=%0d", tag, stall_cycles, exp_stall);
      end
    end
    if (r) begin
      m_freeze = 0; m_drain = 0; m_draining = 0; m_halted = 0; m_stall = 0; m_known = 1;
    end else begin
      if (!m_halted && !pc && m_stall < 65535) m_stall++;
      if (m_halted) begin
      end else if (m_freeze > 0) m_freeze--;
      else if (mm) m_freeze = MISS_LAT - 1;
      else if (m_draining) begin
        if (m_drain == 1) begin m_halted = 1; m_draining = 0; end
        else m_drain--;
      end else if (!br && !lu && hl) begin
        m_draining = 1; m_drain = DRAIN_CYC;
      end
    end
    @(negedge clk);
  endtask
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
  endtask
  initial begin
    @(negedge clk);
    cyc("rst", 1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle("run0", 1);
    cyc("lu", 0, 0, 0, 0, 1, 1, 4'd3, 4'd3, 4'd0, 0);
    idle("lu_after", 1);
    cyc("lu_src2", 0, 0, 0, 0, 1, 1, 4'd5, 4'd1, 4'd5, 1);
    cyc("lu_src2_unused", 0, 0, 0, 0, 1, 1, 4'd5, 4'd1, 4'd5, 0);
    cyc("lu_r0", 0, 0, 0, 0, 1, 1, 4'd0, 4'd0, 4'd0, 1);
    cyc("br_over_lu", 0, 0, 1, 1, 1, 1, 4'd3, 4'd3, 4'd0, 0);
    cyc("miss", 0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle("miss_frz", 3);
    idle("miss_ret", 1);
    cyc("miss_br", 0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    for (int i = 0; i < 3; i++) cyc("miss_br_frz", 0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    cyc("miss_br_ret", 0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    cyc("perf_rst", 1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    cyc("perf_lu", 0, 0, 0, 0, 1, 1, 4'd2, 4'd2, 4'd0, 0);
    cyc("perf_miss", 0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle("perf_frz", 4);
    total++;
`ifdef PERF_CNT_EN
    assert (stall_cycles === 16'd5) else begin
      bad++;
      $error("FAIL perf_total got=%0d exp=5", stall_cycles);
    end
`else
    assert (stall_cycles === 16'd0) else begin
      bad++;
      $error("FAIL perf_total got=%0d exp=0", stall_cycles);
    end
`endif
    cyc("rmiss", 0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle("rmiss_frz", 1);
    cyc("rmiss_rst", 1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle("rmiss_run", 2);
    cyc("halt", 0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    for (int i = 0; i < 3; i++) cyc("drain", 0, 0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle("halted", 3);
    cyc("halt_rst", 1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    cyc("halt2", 0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle("drain2", 1);
    cyc("drain_miss", 0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    idle("drain_frz", 3);
    idle("drain_rest", 4);
    cyc("rnd_rst", 1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
    for (int i = 0; i < 800; i++)
      cyc("rnd", $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 24) == 0, 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
